// File: rtl/sysid_boot_checker.sv
// ============================================================================
//  Module      : sysid_boot_checker
//  Description : Avalon-MM master that reads the downstream system-ID slave
//                (ID word, then timestamp word) and flags boot pass/fail.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS  = 32'h5144_634A,
   parameter int unsigned READ_LATENCY = 0,
   parameter int unsigned AUTO_START   = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass
);

   // The wait state counts down from READ_LATENCY-1 so that it lasts exactly
   // READ_LATENCY cycles; a zero latency skips the wait state entirely.
   localparam logic       c_zero_lat  = (READ_LATENCY == 0);
   localparam logic [3:0] c_wait_init = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);
   localparam logic       c_auto      = (AUTO_START != 0);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ID_REQ  = 3'd1,
      ST_ID_WAIT = 3'd2,
      ST_TS_REQ  = 3'd3,
      ST_TS_WAIT = 3'd4,
      ST_CHECK   = 3'd5
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_auto_pending;
   logic        r_addr;
   logic        r_read;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_id_value;
   logic [31:0] r_ts_value;
   logic        r_id_ok;
   logic        r_ts_ok;
   logic        r_pass;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= 4'd0;
         r_auto_pending <= c_auto;
         r_addr         <= 1'b0;
         r_read         <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_id_value     <= 32'd0;
         r_ts_value     <= 32'd0;
         r_id_ok        <= 1'b0;
         r_ts_ok        <= 1'b0;
         r_pass         <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start || r_auto_pending) begin
                  r_state        <= ST_ID_REQ;
                  r_auto_pending <= 1'b0;
                  r_addr         <= 1'b0;
                  r_read         <= 1'b1;
                  r_busy         <= 1'b1;
               end
            end

            ST_ID_REQ: begin
               r_cnt <= c_wait_init;
               if (c_zero_lat) begin
                  r_id_value <= sysid_readdata;
                  r_state    <= ST_TS_REQ;
                  r_addr     <= 1'b1;
                  r_read     <= 1'b1;
               end else begin
                  r_state    <= ST_ID_WAIT;
                  r_read     <= 1'b0;
               end
            end

            ST_ID_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_id_value <= sysid_readdata;
                  r_state    <= ST_TS_REQ;
                  r_addr     <= 1'b1;
                  r_read     <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            ST_TS_REQ: begin
               r_cnt <= c_wait_init;
               r_read <= 1'b0;
               if (c_zero_lat) begin
                  r_ts_value <= sysid_readdata;
                  r_state    <= ST_CHECK;
               end else begin
                  r_state    <= ST_TS_WAIT;
               end
            end

            ST_TS_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_ts_value <= sysid_readdata;
                  r_state    <= ST_CHECK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            ST_CHECK: begin
               r_id_ok <= (r_id_value == EXPECTED_ID);
               r_ts_ok <= (r_ts_value == EXPECTED_TS);
               r_pass  <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_addr  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               r_read  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sysid_address = r_addr;
   assign sysid_read    = r_read;
   assign busy          = r_busy;
   assign done          = r_done;
   assign id_value      = r_id_value;
   assign ts_value      = r_ts_value;
   assign id_ok         = r_id_ok;
   assign ts_ok         = r_ts_ok;
   assign pass          = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
// ============================================================================
//  Module      : tb_sysid_boot_checker
//  Description : Bench for sysid_boot_checker with a zero-latency and a
//                three-cycle-latency instance sharing one clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sysid_boot_checker;

   localparam logic [31:0] ID0 = 32'h0000_0000;
   localparam logic [31:0] ID1 = 32'hA5A5_0001;
   localparam logic [31:0] TSX = 32'h5144_634A;
   localparam int          L0  = 0;
   localparam int          L1  = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  start = 2'b00;
   logic [1:0]  sysid_address, sysid_read, busy, done, id_ok, ts_ok, pass;
   logic [31:0] readdata [2];
   logic [31:0] id_value [2];
   logic [31:0] ts_value [2];

   always #5 clock = ~clock;

   sysid_boot_checker #(.EXPECTED_ID(ID0), .EXPECTED_TS(TSX), .READ_LATENCY(L0), .AUTO_START(1)) u_dut0 (
      .clock(clock), .reset(reset), .start(start[0]),
      .sysid_address(sysid_address[0]), .sysid_read(sysid_read[0]), .sysid_readdata(readdata[0]),
      .busy(busy[0]), .done(done[0]), .id_value(id_value[0]), .ts_value(ts_value[0]),
      .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .pass(pass[0]));

   sysid_boot_checker #(.EXPECTED_ID(ID1), .EXPECTED_TS(TSX), .READ_LATENCY(L1), .AUTO_START(0)) u_dut1 (
      .clock(clock), .reset(reset), .start(start[1]),
      .sysid_address(sysid_address[1]), .sysid_read(sysid_read[1]), .sysid_readdata(readdata[1]),
      .busy(busy[1]), .done(done[1]), .id_value(id_value[1]), .ts_value(ts_value[1]),
      .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .pass(pass[1]));

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Slave contents and per-instance configuration
   logic [31:0] id_word [2];
   logic [31:0] ts_word [2];
   logic [31:0] exp_id_c [2] = '{ID0, ID1};
   int          lat [2]      = '{L0, L1};
   logic        auto_c [2]   = '{1'b1, 1'b0};

   // Reference model: each check is described by the cycle T in which its
   // start was sampled; every output is a function of the offset k = now - T.
   int          cyc = 0;
   int          mk;
   logic        m_act [2];
   int          m_t [2];
   logic        m_pend [2];
   logic [1:0]  e_busy, e_read, e_addr, e_done, e_id_ok, e_ts_ok, e_pass;
   logic [31:0] e_idv [2];
   logic [31:0] e_tsv [2];

   always @(posedge clock) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_act[i]  = 1'b0;
            m_t[i]    = 0;
            m_pend[i] = auto_c[i];
            e_busy[i] = 1'b0; e_read[i] = 1'b0; e_addr[i] = 1'b0; e_done[i] = 1'b0;
            e_id_ok[i] = 1'b0; e_ts_ok[i] = 1'b0; e_pass[i] = 1'b0;
            e_idv[i]  = 32'd0; e_tsv[i] = 32'd0;
         end else begin
            if ((!m_act[i] || (cyc - 1 - m_t[i]) >= 4 + 2 * lat[i]) && (start[i] || m_pend[i])) begin
               m_act[i]  = 1'b1;
               m_t[i]    = cyc - 1;
               m_pend[i] = 1'b0;
            end
            mk = cyc - m_t[i];
            e_busy[i] = m_act[i] && mk >= 1 && mk <= 3 + 2 * lat[i];
            e_read[i] = m_act[i] && (mk == 1 || mk == 2 + lat[i]);
            e_addr[i] = (mk != 1);
            e_done[i] = m_act[i] && mk == 4 + 2 * lat[i];
            if (m_act[i] && mk == 2 + lat[i]) e_idv[i] = id_word[i];
            if (m_act[i] && mk == 3 + 2 * lat[i]) e_tsv[i] = ts_word[i];
            if (e_done[i]) begin
               e_id_ok[i] = (e_idv[i] == exp_id_c[i]);
               e_ts_ok[i] = (e_tsv[i] == TSX);
               e_pass[i]  = e_id_ok[i] && e_ts_ok[i];
            end
         end
      end
   end

   // Per-cycle comparison, then the slave model drives readdata for this cycle
   logic hist_rd [2][16];
   logic hist_ad [2][16];

   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("busy%0d", i),  32'(busy[i]),       32'(e_busy[i]));
         chk($sformatf("read%0d", i),  32'(sysid_read[i]), 32'(e_read[i]));
         chk($sformatf("done%0d", i),  32'(done[i]),       32'(e_done[i]));
         chk($sformatf("id_ok%0d", i), 32'(id_ok[i]),      32'(e_id_ok[i]));
         chk($sformatf("ts_ok%0d", i), 32'(ts_ok[i]),      32'(e_ts_ok[i]));
         chk($sformatf("pass%0d", i),  32'(pass[i]),       32'(e_pass[i]));
         chk($sformatf("id_value%0d", i), id_value[i], e_idv[i]);
         chk($sformatf("ts_value%0d", i), ts_value[i], e_tsv[i]);
         if (e_read[i])
            chk($sformatf("addr%0d", i), 32'(sysid_address[i]), 32'(e_addr[i]));

         hist_rd[i][cyc % 16] = sysid_read[i];
         hist_ad[i][cyc % 16] = sysid_address[i];
         if (cyc >= lat[i] && hist_rd[i][(cyc - lat[i]) % 16])
            readdata[i] = hist_ad[i][(cyc - lat[i]) % 16] ? ts_word[i] : id_word[i];
         else
            readdata[i] = $urandom;
      end
   end

   task automatic tick;
      @(negedge clock);
      #1;
   endtask

   function automatic logic [31:0] pick(input logic [31:0] e);
      case ($urandom_range(0, 3))
         0, 1:    return e;
         2:       return e ^ (32'd1 << $urandom_range(0, 31));
         default: return $urandom;
      endcase
   endfunction

   int rdcnt;
   int dncnt;

   initial begin
      id_word[0] = ID0; ts_word[0] = TSX;
      id_word[1] = ID1; ts_word[1] = TSX;
      readdata[0] = 32'd0; readdata[1] = 32'd0;

      // Reset state
      repeat (3) tick;
      for (int i = 0; i < 2; i++) begin
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_read", 32'(sysid_read[i]), 32'd0);
         chk("rst_addr", 32'(sysid_address[i]), 32'd0);
         chk("rst_done", 32'(done[i]), 32'd0);
         chk("rst_pass", 32'(pass[i]), 32'd0);
         chk("rst_ts_value", ts_value[i], 32'd0);
      end
      reset = 1'b0;

      // Auto-start on instance 0 only
      tick;
      chk("auto_read", 32'(sysid_read[0]), 32'd1);
      chk("noauto_busy1", 32'(busy[1]), 32'd0);
      repeat (3) tick;
      chk("auto_done", 32'(done[0]), 32'd1);
      chk("auto_pass", 32'(pass[0]), 32'd1);
      repeat (4) tick;

      // L=0 passing check: reads at T+1, T+2, done at T+4
      start[0] = 1'b1; tick; start[0] = 1'b0;
      chk("t1_read_id", 32'({sysid_read[0], sysid_address[0]}), 32'b10);
      tick;
      chk("t1_read_ts", 32'({sysid_read[0], sysid_address[0]}), 32'b11);
      tick;
      chk("t1_busy_T3", 32'(busy[0]), 32'd1);
      tick;
      chk("t1_done", 32'({done[0], busy[0], pass[0], id_ok[0], ts_ok[0]}), 32'b10111);
      repeat (2) tick;

      // Bad timestamp; pass holds until this check's done
      ts_word[0] = 32'h5144_634B;
      start[0] = 1'b1; tick; start[0] = 1'b0;
      repeat (2) tick;
      chk("t6_pass_held", 32'(pass[0]), 32'd1);
      tick;
      chk("t2_flags", 32'({done[0], pass[0], id_ok[0], ts_ok[0]}), 32'b1010);
      chk("t2_ts_value", ts_value[0], 32'h5144_634B);
      repeat (2) tick;
      ts_word[0] = TSX;

      // L=3: done at T+10, exactly two read strobes
      start[1] = 1'b1; tick; start[1] = 1'b0;
      rdcnt = int'(sysid_read[1]);
      repeat (8) begin tick; rdcnt += int'(sysid_read[1]); end
      chk("t3_done_T9", 32'(done[1]), 32'd0);
      tick;
      chk("t3_done_T10", 32'({done[1], pass[1]}), 32'b11);
      chk("t3_reads", 32'(rdcnt), 32'd2);
      repeat (2) tick;

      // Starts during a check are ignored
      start[0] = 1'b1; tick; start[0] = 1'b0;
      dncnt = int'(done[0]);
      for (int j = 2; j <= 12; j++) begin
         tick;
         start[0] = (j == 2 || j == 3);
         dncnt += int'(done[0]);
      end
      chk("t4_done_count", 32'(dncnt), 32'd1);
      chk("t4_pass", 32'(pass[0]), 32'd1);

      // Reset mid-check, then auto-start reruns
      start[0] = 1'b1; tick; start[0] = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      chk("t5_rst_outs", 32'({busy[0], sysid_read[0], done[0], pass[0], id_ok[0], ts_ok[0]}), 32'd0);
      chk("t5_rst_ts_value", ts_value[0], 32'd0);
      reset = 1'b0;
      repeat (3) tick;
      chk("t5_busy", 32'({busy[0], done[0]}), 32'b10);
      tick;
      chk("t5_done", 32'({done[0], pass[0]}), 32'b11);
      repeat (2) tick;

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         tick;
         reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 2; i++) begin
            start[i] = ($urandom_range(0, 5) == 0);
            if (!e_busy[i] && $urandom_range(0, 3) == 0) begin
               id_word[i] = pick(exp_id_c[i]);
               ts_word[i] = pick(TSX);
            end
         end
      end
      reset = 1'b0;
      start = 2'b00;
      repeat (20) tick;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
